// File: rtl/step_feeder_pkg.sv
// step_feeder_pkg: shared types and constants for the step command feeder.
//   state_t  - dispatch FSM states
//   CMD_W    - command byte width
//   DIR_BIT  - direction bit position within a command
//   CNT_MSB  - top bit of the step-count field (count occupies CNT_MSB:0)
package step_feeder_pkg;

    localparam int CMD_W   = 8;
    localparam int DIR_BIT = 7;
    localparam int CNT_MSB = 6;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        STROBE,
        WAIT_ACK,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/step_cmd_fifo.sv
// step_cmd_fifo: synchronous command FIFO with wrap-bit pointers.
//   clk, rst_n   - clock, asynchronous active-low reset (pointers only)
//   push, din    - write request and data; accepted when not full or popping
//   pop, dout    - read request and head-of-queue data (pop only when !empty)
//   full, empty  - occupancy flags
//   level        - number of stored entries
module step_cmd_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             din,
    input  logic                     pop,
    output logic [W-1:0]             dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wptr, rptr;
    logic         wr_ok;

    // A simultaneous pop frees the slot the push lands in, so full does not block it.
    assign wr_ok = push && (!full || pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem[wptr[AW-1:0]] <= din;
    end

    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign empty = wptr == rptr;
    assign level = wptr - rptr;
    assign dout  = mem[rptr[AW-1:0]];

endmodule

// File: rtl/step_cmd_feeder.sv
// step_cmd_feeder: buffers MCU step commands and strobes them into the pulse generator.
//   clk, rst_n        - 20 MHz clock, asynchronous active-low reset
//   host_data/host_wr - command byte and asynchronous MCU write strobe
//   en                - dispatch enable
//   clr_flags         - one-cycle pulse clearing ovf/udf/ack_err
//   gen_busy          - generator busy, same clock domain
//   N, WR             - command and write strobe to the generator
//   fifo_full/empty   - FIFO status, level = occupancy
//   ovf/udf/ack_err   - sticky overflow, underrun and missed-acknowledge flags
module step_cmd_feeder
    import step_feeder_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WR_HIGH     = 4,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [CMD_W-1:0]       host_data,
    input  logic                   host_wr,
    input  logic                   en,
    input  logic                   clr_flags,
    input  logic                   gen_busy,
    output logic [CMD_W-1:0]       N,
    output logic                   WR,
    output logic                   fifo_full,
    output logic                   fifo_empty,
    output logic [$clog2(DEPTH):0] level,
    output logic                   ovf,
    output logic                   udf,
    output logic                   ack_err
);

    localparam int CMAX = (WR_HIGH > ACK_TIMEOUT) ? WR_HIGH : ACK_TIMEOUT;
    localparam int CW   = $clog2(CMAX) + 1;

    state_t           state, state_n;
    logic [CW-1:0]    cnt;
    logic [2:0]       hs;
    logic             push, pop, armed, set_ack, set_udf, set_ovf;
    logic [CMD_W-1:0] head;

    // hs[1:0] synchronise host_wr; hs[2] is the previous synchronised value for edge detect.
    assign push    = hs[1] & ~hs[2];
    assign set_ovf = push && fifo_full && !pop;

    step_cmd_fifo #(.DEPTH(DEPTH), .W(CMD_W)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (host_data),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (level)
    );

    always_comb begin
        state_n = state;
        pop     = 1'b0;
        set_ack = 1'b0;
        set_udf = 1'b0;
        case (state)
            IDLE:      if (en && !fifo_empty && !gen_busy) begin
                           pop     = 1'b1;
                           state_n = SETUP;
                       end
            SETUP:     state_n = STROBE;
            STROBE:    if (cnt == CW'(WR_HIGH - 1)) state_n = WAIT_ACK;
            WAIT_ACK:  if (gen_busy) state_n = WAIT_DONE;
                       else if (cnt == CW'(ACK_TIMEOUT - 1)) begin
                           set_ack = 1'b1;
                           state_n = IDLE;
                       end
            WAIT_DONE: if (!gen_busy) begin
                           state_n = IDLE;
                           set_udf = fifo_empty && armed;
                       end
            default:   state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            hs      <= '0;
            N       <= '0;
            WR      <= 1'b0;
            armed   <= 1'b0;
            ovf     <= 1'b0;
            udf     <= 1'b0;
            ack_err <= 1'b0;
        end else begin
            state   <= state_n;
            // cnt restarts on every state change, so it times the current state's dwell.
            cnt     <= (state_n != state) ? '0 : cnt + 1'b1;
            hs      <= {hs[1:0], host_wr};
            WR      <= state_n == STROBE;
            N       <= pop ? head : N;
            armed   <= pop ? 1'b1 : (set_udf ? 1'b0 : armed);
            ovf     <= set_ovf | (ovf & ~clr_flags);
            udf     <= set_udf | (udf & ~clr_flags);
            ack_err <= set_ack | (ack_err & ~clr_flags);
        end
    end

endmodule

// File: tb/tb_step_cmd_feeder.sv
// tb_step_cmd_feeder: scoreboard bench for step_cmd_feeder with a busy-generator stub.
module tb_step_cmd_feeder;

    localparam int DEPTH       = 8;
    localparam int WR_HIGH     = 4;
    localparam int ACK_TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [7:0] host_data = '0;
    logic       host_wr = 1'b0;
    logic       en = 1'b0;
    logic       clr_flags = 1'b0;
    logic       gen_busy = 1'b0;
    logic [7:0] N;
    logic       WR, fifo_full, fifo_empty, ovf, udf, ack_err;
    logic [3:0] level;

    int         checks = 0;
    int         failures = 0;
    int         rises = 0;
    logic [7:0] exp_q[$];
    int         stub_mode = 0;
    int         stub_delay = 2;
    int         stub_hold = 6;
    bit         stub_rand = 1'b0;

    always #25 clk = ~clk;

    step_cmd_feeder #(.DEPTH(DEPTH), .WR_HIGH(WR_HIGH), .ACK_TIMEOUT(ACK_TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .host_data  (host_data),
        .host_wr    (host_wr),
        .en         (en),
        .clr_flags  (clr_flags),
        .gen_busy   (gen_busy),
        .N          (N),
        .WR         (WR),
        .fifo_full  (fifo_full),
        .fifo_empty (fifo_empty),
        .level      (level),
        .ovf        (ovf),
        .udf        (udf),
        .ack_err    (ack_err)
    );

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: every WR rising edge must present the oldest expected command.
    initial begin : mon
        logic       prev_wr, prev_busy;
        logic [7:0] prev_n, e;
        int         hi;
        prev_wr = 1'b0;
        prev_busy = 1'b0;
        prev_n = '0;
        hi = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_wr = 1'b0;
                hi = 0;
            end else begin
                if (WR && !prev_wr) begin
                    rises++;
                    chk("busy_at_strobe", {31'd0, prev_busy}, 0);
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_dispatch: got N=0x%0h expected no strobe", N);
                    end else begin
                        e = exp_q.pop_front();
                        chk("n_dispatch", {24'd0, N}, {24'd0, e});
                        chk("n_setup", {24'd0, prev_n}, {24'd0, e});
                    end
                end
                if (WR) hi++;
                else if (prev_wr) begin
                    chk("wr_width", hi, WR_HIGH);
                    hi = 0;
                end
                prev_wr = WR;
            end
            prev_n = N;
            prev_busy = gen_busy;
        end
    end

    // Generator stub: goes busy some cycles after each WR rising edge.
    initial begin : stub
        int d, h;
        forever begin
            @(posedge WR);
            if (stub_mode == 0) begin
                d = stub_rand ? int'($urandom_range(0, 6)) : stub_delay;
                h = stub_rand ? int'($urandom_range(WR_HIGH + 2, 20)) : stub_hold;
                repeat (d) @(posedge clk);
                #1 gen_busy = 1'b1;
                repeat (h) @(posedge clk);
                #1 gen_busy = 1'b0;
            end
        end
    end

    task automatic host_write(logic [7:0] d, bit acc);
        @(negedge clk);
        host_data = d;
        host_wr = 1'b1;
        if (acc) exp_q.push_back(d);
        repeat (4) @(negedge clk);
        host_wr = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr_flags = 1'b1;
        @(negedge clk);
        clr_flags = 1'b0;
    endtask

    task automatic wait_drain(int budget);
        int n, q;
        n = 0;
        q = 0;
        while (q < 8 && n < budget) begin
            @(negedge clk);
            n++;
            q = (exp_q.size() == 0 && !gen_busy && !WR) ? q + 1 : 0;
        end
        checks++;
        if (q < 8) begin
            failures++;
            $display("FAIL drain_timeout: got %0d pending expected 0 within %0d cycles", exp_q.size(), budget);
        end
    endtask

    task automatic wait_wr(logic lvl, int budget);
        int n;
        n = 0;
        while (WR !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (WR !== lvl) begin
            failures++;
            $display("FAIL wr_timeout: got WR=%b expected %b within %0d cycles", WR, lvl, budget);
        end
    endtask

    initial begin : main
        int k, r0;
        logic [7:0] d;
        #1 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_n_out", {24'd0, N}, 0);
        chk("rst_wr", {31'd0, WR}, 0);
        chk("rst_full", {31'd0, fifo_full}, 0);
        chk("rst_empty", {31'd0, fifo_empty}, 1);
        chk("rst_level", {28'd0, level}, 0);
        chk("rst_flags", {29'd0, ovf, udf, ack_err}, 0);
        rst_n = 1'b1;
        en = 1'b1;

        // single command, long busy, then underrun
        stub_delay = 2;
        stub_hold = 200;
        host_write(8'h32, 1'b1);
        wait_drain(400);
        chk("t1_empty", {31'd0, fifo_empty}, 1);
        chk("t1_udf", {31'd0, udf}, 1);
        pulse_clr();
        chk("t1_clr_udf", {31'd0, udf}, 0);

        // three queued commands dispatched in order
        stub_hold = 6;
        en = 1'b0;
        host_write(8'h85, 1'b1);
        host_write(8'h10, 1'b1);
        host_write(8'h7F, 1'b1);
        chk("t2_level3", {28'd0, level}, 3);
        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wait_wr(1'b1, 100);
            chk("t2_level", {28'd0, level}, 32'(2 - i));
            wait_wr(1'b0, 100);
        end
        wait_drain(400);

        // overflow: ninth write lost
        en = 1'b0;
        pulse_clr();
        for (int i = 0; i < 9; i++) host_write(8'(8'h40 + i), i < 8);
        chk("t3_full", {31'd0, fifo_full}, 1);
        chk("t3_level", {28'd0, level}, 8);
        chk("t3_ovf", {31'd0, ovf}, 1);
        en = 1'b1;
        wait_drain(2000);
        chk("t3_level_end", {28'd0, level}, 0);

        // missing acknowledge
        pulse_clr();
        stub_mode = 1;
        host_write(8'h5A, 1'b1);
        wait_wr(1'b1, 50);
        wait_wr(1'b0, 50);
        k = 0;
        while (!ack_err && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("t4_ack_latency", k, ACK_TIMEOUT);
        stub_mode = 0;
        pulse_clr();
        chk("t4_clr_ack", {31'd0, ack_err}, 0);
        r0 = rises;
        host_write(8'hA5, 1'b1);
        wait_drain(400);
        chk("t4_redispatch", rises, r0 + 1);

        // reset during strobe
        chk("t5_pre_udf", {31'd0, udf}, 1);
        stub_hold = 10;
        en = 1'b0;
        host_write(8'h11, 1'b1);
        host_write(8'h22, 1'b1);
        en = 1'b1;
        wait_wr(1'b1, 50);
        @(negedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("t5_wr_async", {31'd0, WR}, 0);
        chk("t5_level", {28'd0, level}, 0);
        chk("t5_flags", {29'd0, ovf, udf, ack_err}, 0);
        exp_q.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        r0 = rises;
        repeat (30) @(negedge clk);
        chk("t5_no_dispatch", rises, r0);
        host_write(8'h77, 1'b1);
        wait_drain(400);

        // push while full coinciding with a pop
        pulse_clr();
        stub_hold = 6;
        en = 1'b0;
        for (int i = 0; i < 8; i++) host_write(8'($urandom), 1'b1);
        chk("t6_level_full", {28'd0, level}, 8);
        @(negedge clk);
        host_data = 8'hC3;
        host_wr = 1'b1;
        exp_q.push_back(8'hC3);
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
        chk("t6_level_same", {28'd0, level}, 8);
        chk("t6_no_ovf", {31'd0, ovf}, 0);
        @(negedge clk);
        host_wr = 1'b0;
        wait_drain(2000);

        // randomized traffic
        pulse_clr();
        stub_rand = 1'b1;
        for (int i = 0; i < 60; i++) begin
            en = ($urandom_range(0, 3) != 0);
            d = 8'($urandom);
            if (exp_q.size() < DEPTH) host_write(d, 1'b1);
            else repeat (5) @(negedge clk);
            repeat ($urandom_range(0, 8)) @(negedge clk);
        end
        en = 1'b1;
        wait_drain(5000);
        chk("rnd_ovf", {31'd0, ovf}, 0);
        chk("rnd_ack", {31'd0, ack_err}, 0);
        chk("rnd_level", {28'd0, level}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
